// File: rtl/bufm_id_mgr.sv
`default_nettype none
// ============================================================================
// Module   : bufm_id_mgr
// Purpose  : Owns the pool of bufm packet-buffer IDs as a circular free list.
//            Grants or refuses one ID per packet header using priority-based
//            admission thresholds, takes back released IDs, and reports the
//            free-ID count plus allocation statistics.
// Ports    : clk, rst_n            - clock, asynchronous active-low reset
//            alloc_req/alloc_pri   - allocation request pulse and priority
//            alloc_ack/alloc_nack  - one-cycle grant / refusal pulses
//            alloc_id              - granted ID (valid with alloc_ack)
//            rel_wr/rel_id         - release pulse and returned ID
//            free_cnt              - IDs currently in the free list
//            init_done             - free list fully loaded
//            alloc_ok_cnt          - granted-request count (wraps)
//            alloc_drop_cnt        - refused-request count (wraps)
//            rel_err/rel_err_cnt   - bogus-release pulse and count
//                                    (only with BUFM_ID_CHK_EN)
// Options  : `define BUFM_ID_CHK_EN adds an in-use bitmap that rejects
//            releases of IDs that are not currently allocated.
// Revision : 1.0 - initial release
// ============================================================================
module bufm_id_mgr #(
    parameter int ID_W   = 4,
    parameter int ID_NUM = 16,
    parameter int CNT_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alloc_req,
    input  logic [2:0]       alloc_pri,
    output logic             alloc_ack,
    output logic             alloc_nack,
    output logic [ID_W-1:0]  alloc_id,
    input  logic             rel_wr,
    input  logic [ID_W-1:0]  rel_id,
    output logic [CNT_W-1:0] free_cnt,
    output logic             init_done,
    output logic [31:0]      alloc_ok_cnt,
    output logic [31:0]      alloc_drop_cnt
`ifdef BUFM_ID_CHK_EN
    ,
    output logic             rel_err,
    output logic [15:0]      rel_err_cnt
`endif
);

    localparam logic [0:0]       c_st_init  = 1'b0;
    localparam logic [0:0]       c_st_run   = 1'b1;
    localparam logic [CNT_W-1:0] c_cnt_full = CNT_W'(ID_NUM);
    localparam logic [CNT_W-1:0] c_thr_p0   = CNT_W'(4);
    localparam logic [CNT_W-1:0] c_thr_p1   = CNT_W'(2);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [ID_W-1:0]  c_last_id  = ID_W'(ID_NUM - 1);
    localparam logic [ID_W-1:0]  c_id_one   = ID_W'(1);

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [ID_W-1:0]  r_free_list [ID_NUM];
    logic [ID_W-1:0]  r_rd_ptr;
    logic [ID_W-1:0]  r_wr_ptr;
    logic [CNT_W-1:0] r_free_cnt;
    logic             r_ack;
    logic             r_nack;
    logic [ID_W-1:0]  r_alloc_id;
    logic [31:0]      r_ok_cnt;
    logic [31:0]      r_drop_cnt;

    logic             w_in_run;
    logic             w_load;
    logic             w_thresh_ok;
    logic             w_grant;
    logic             w_refuse;
    logic             w_rel_valid;
    logic             w_rel_ok;
    logic             w_cnt_inc;
    logic [ID_W-1:0]  w_grant_id;

    // ------------------------------------------------------------------
    // State machine: INIT loads IDs 0..ID_NUM-1, then RUN forever.
    // During INIT the write pointer doubles as the load counter.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_init;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_init: begin
                if (r_wr_ptr == c_last_id) begin
                    w_state_nxt = c_st_run;
                end
            end
            default: w_state_nxt = c_st_run;
        endcase
    end

    assign w_in_run = (r_state == c_st_run);
    assign w_load   = ~w_in_run;

    // Admission thresholds keep headroom for higher-priority traffic.
    always_comb begin
        case (alloc_pri)
            3'd0:    w_thresh_ok = (r_free_cnt >= c_thr_p0);
            3'd1:    w_thresh_ok = (r_free_cnt >= c_thr_p1);
            default: w_thresh_ok = (r_free_cnt >= c_cnt_one);
        endcase
    end

    assign w_grant    = alloc_req & w_in_run & w_thresh_ok;
    assign w_refuse   = alloc_req & ~w_grant;
    assign w_grant_id = r_free_list[r_rd_ptr];

    // A release is only committed in RUN and never past a full list.
    // The grant reads the pre-edge head entry, so an ID released in the
    // same cycle cannot be handed out until the following cycle.
    assign w_rel_ok  = rel_wr & w_in_run & w_rel_valid & (r_free_cnt != c_cnt_full);
    assign w_cnt_inc = w_load | w_rel_ok;

    // Free-list storage is rebuilt by INIT after every reset, so it needs
    // no reset of its own.
    always_ff @(posedge clk) begin
        if (w_load) begin
            r_free_list[r_wr_ptr] <= r_wr_ptr;
        end else if (w_rel_ok) begin
            r_free_list[r_wr_ptr] <= rel_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_free_cnt <= '0;
            r_ack      <= 1'b0;
            r_nack     <= 1'b0;
            r_alloc_id <= '0;
            r_ok_cnt   <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_ack  <= w_grant;
            r_nack <= w_refuse;
            if (w_grant) begin
                r_alloc_id <= w_grant_id;
                r_rd_ptr   <= r_rd_ptr + c_id_one;
                r_ok_cnt   <= r_ok_cnt + 32'd1;
            end
            if (w_refuse) begin
                r_drop_cnt <= r_drop_cnt + 32'd1;
            end
            if (w_cnt_inc) begin
                r_wr_ptr <= r_wr_ptr + c_id_one;
            end
            // Grant and release in the same cycle cancel out.
            case ({w_cnt_inc, w_grant})
                2'b10:   r_free_cnt <= r_free_cnt + c_cnt_one;
                2'b01:   r_free_cnt <= r_free_cnt - c_cnt_one;
                default: r_free_cnt <= r_free_cnt;
            endcase
        end
    end

`ifdef BUFM_ID_CHK_EN
    // ------------------------------------------------------------------
    // In-use bitmap: a release is only honoured for an allocated ID.
    // ------------------------------------------------------------------
    logic [ID_NUM-1:0] r_in_use;
    logic [ID_NUM-1:0] w_set_mask;
    logic [ID_NUM-1:0] w_clr_mask;
    logic              w_rel_bogus;
    logic              r_rel_err;
    logic [15:0]       r_rel_err_cnt;

    assign w_rel_valid = r_in_use[rel_id];
    assign w_rel_bogus = rel_wr & w_in_run & ~r_in_use[rel_id];

    always_comb begin
        w_set_mask = '0;
        w_clr_mask = '0;
        if (w_grant) begin
            w_set_mask = ID_NUM'(1) << w_grant_id;
        end
        if (w_rel_ok) begin
            w_clr_mask = ID_NUM'(1) << rel_id;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_use      <= '0;
            r_rel_err     <= 1'b0;
            r_rel_err_cnt <= '0;
        end else begin
            r_in_use  <= (r_in_use & ~w_clr_mask) | w_set_mask;
            r_rel_err <= w_rel_bogus;
            if (w_rel_bogus) begin
                r_rel_err_cnt <= r_rel_err_cnt + 16'd1;
            end
        end
    end

    assign rel_err     = r_rel_err;
    assign rel_err_cnt = r_rel_err_cnt;
`else
    assign w_rel_valid = 1'b1;
`endif

    assign alloc_ack      = r_ack;
    assign alloc_nack     = r_nack;
    assign alloc_id       = r_alloc_id;
    assign free_cnt       = r_free_cnt;
    assign init_done      = w_in_run;
    assign alloc_ok_cnt   = r_ok_cnt;
    assign alloc_drop_cnt = r_drop_cnt;

endmodule
`default_nettype wire

// File: doc/bufm_id_mgr.md
Name: bufm_id_mgr

Overview:
- Owns the pool of packet-buffer IDs used by bufm and keeps it as a circular free list.
- Grants or refuses one ID per packet header from the pac stage, using priority-based admission thresholds.
- Takes back IDs released by the output side after a packet is transmitted.
- Drives the free-ID count that pac uses for traffic regulation, plus the allocation statistics read by lcm.

Parameters:
- ID_W, 4, width of a buffer ID.
- ID_NUM, 16, number of buffer IDs; must equal 2**ID_W.
- CNT_W, 5, width of free_cnt; must hold the value ID_NUM.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- alloc_req  in  1  one-cycle pulse: request one ID for a new packet
- alloc_pri  in  3  priority of the request (pac action[8:6])
- alloc_ack  out  1  one-cycle pulse: request granted
- alloc_nack  out  1  one-cycle pulse: request refused, so the packet is discarded
- alloc_id  out  ID_W  granted ID; valid only when alloc_ack=1
- rel_wr  in  1  one-cycle pulse: return an ID to the pool
- rel_id  in  ID_W  the ID being returned
- free_cnt  out  CNT_W  number of IDs currently in the free list
- init_done  out  1  high once the free list is fully loaded
- alloc_ok_cnt  out  32  count of granted requests
- alloc_drop_cnt  out  32  count of refused requests

Behaviour:
- Reset values: all outputs 0; rd_ptr=0, wr_ptr=0; state=INIT_S.
- Free list: ID_NUM x ID_W register array. rd_ptr and wr_ptr are ID_W bits wide and wrap naturally. free_cnt tracks occupancy.
- INIT_S: on each cycle, write the load counter k to entry k, advance wr_ptr and increment free_cnt. After writing k=ID_NUM-1, move to RUN_S and set init_done=1 on the next cycle. INIT_S therefore lasts exactly ID_NUM cycles after reset release.
- Requests in INIT_S: any alloc_req is refused with alloc_nack and increments alloc_drop_cnt. rel_wr is ignored.
- Admission in RUN_S: alloc_req is sampled in cycle N using the registered free_cnt.
  - alloc_pri=0 is granted only if free_cnt>=4.
  - alloc_pri=1 is granted only if free_cnt>=2.
  - alloc_pri>=2 is granted only if free_cnt>=1.
- Grant: in cycle N+1, alloc_ack=1 and alloc_id=entry[rd_ptr]; rd_ptr increments, free_cnt decrements and alloc_ok_cnt increments.
- Refusal: in cycle N+1, alloc_nack=1, alloc_id holds its previous value and alloc_drop_cnt increments.
- Release in RUN_S: rel_id is written to entry[wr_ptr], wr_ptr increments and free_cnt increments, all effective the next cycle.
- Release bypass: a released ID is not available to an allocation sampled in the same cycle. With free_cnt=0, a simultaneous rel_wr and alloc_req results in a nack and free_cnt=1.
- Simultaneous grant and release: both pointers move and free_cnt is unchanged.
- Overflow guard: a release while free_cnt==ID_NUM is dropped and no state changes.
- Counter width: both statistics counters are 32 bits and wrap from 0xFFFFFFFF to 0.
- Reset during operation: all state returns to reset values, including pointers and counters, and INIT_S is re-entered. IDs held by downstream are considered lost and the pool is rebuilt from scratch.
- Pulse separation: alloc_ack and alloc_nack are never high in the same cycle. Each request produces exactly one response.

Optional Feature:
BUFM_ID_CHK_EN
- Enabled:
  - Maintain an ID_NUM-bit in-use bitmap: set on grant, cleared on accepted release.
  - A release of an ID whose bit is 0 is a duplicate or bogus release. It is ignored with no free-list write and no pointer or count change.
  - That release pulses extra output port rel_err (1 bit, reset 0) for one cycle and increments extra output port rel_err_cnt (16 bits, wraps).
  - The bitmap is cleared by reset.
- Disabled: no bitmap; every release is accepted except those blocked by the overflow guard; rel_err and rel_err_cnt do not exist.

Test Plan:
- Release rst_n and idle 16 cycles: init_done rises at cycle 17; free_cnt=16. Then four alloc_req with pri=2 yield alloc_id 0,1,2,3 and free_cnt=12.
- Allocate with pri=2 until free_cnt=0, then one more request: alloc_nack, alloc_drop_cnt=1, alloc_ok_cnt=16.
- Threshold check at free_cnt=3: pri=0 gives nack; pri=1 gives ack with free_cnt=2; next pri=1 gives ack with free_cnt=1; next pri=1 gives nack; pri=5 gives ack with free_cnt=0.
- At free_cnt=0, pulse rel_wr with rel_id=7 together with a pri=2 alloc_req: nack and free_cnt=1. The next pri=2 request returns alloc_id=7.
- With BUFM_ID_CHK_EN: release ID 9 twice after granting it once. The first release makes free_cnt +1; the second pulses rel_err, sets rel_err_cnt=1 and leaves free_cnt unchanged. At free_cnt=16 with the macro off, a release leaves free_cnt=16.
- Assert rst_n low mid-allocation: all outputs go to 0 asynchronously. After release, INIT repeats and the first grant returns ID 0.
